uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter STOP_BITS, default 1, number of stop bits (legal 1..2).
REQ-003 clk_in  input  1  system clock; all logic on posedge clk_in.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 baud_clk  input  1  divided baud clock from the divider stage, synchronous to clk_in; treated as data, never used as a clock.
REQ-006 data_in  input  DATA_BITS  byte to transmit.
REQ-007 valid_in  input  1  data_in valid.
REQ-008 ready_out  output  1  block can accept a byte.
REQ-009 tx_out  output  1  serial line, idle high.
REQ-010 busy  output  1  frame in progress, including wait-for-tick.

Function
REQ-011 Baud tick SHALL be a one-clk_in pulse, asserted when baud_clk is 1 and its registered copy baud_q is 0.
REQ-012 Accept SHALL occur when valid_in && ready_out; data_in latched into a shift register in the same edge; ready_out low and busy high from the next cycle.
REQ-013 States: IDLE, WAIT, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE: ready_out=1, busy=0, tx_out=1; on accept -> WAIT; a tick in the accept cycle is ignored.
REQ-015 WAIT: tx_out=1; on tick -> START, tx_out<=0.
REQ-016 START: on tick -> DATA, tx_out<=bit 0, bit_cnt<=0.
REQ-017 DATA: on tick, bit_cnt<DATA_BITS-1 -> tx_out<=next bit (LSB first), bit_cnt+1; bit_cnt==DATA_BITS-1 -> PARITY (tx_out<=parity) or STOP (tx_out<=1).
REQ-018 STOP: tx_out=1; on tick, stop_cnt==STOP_BITS-1 -> IDLE, else stop_cnt+1.
REQ-019 tx_out SHALL be registered, changing one clk_in after the tick cycle; each bit lasts exactly one baud_clk period.
REQ-020 valid_in while ready_out=0 SHALL be ignored; no queueing.
REQ-021 Next frame SHALL be accepted in the cycle after return to IDLE; back-to-back frames separated by at least one WAIT tick.
REQ-022 bit_cnt and stop_cnt SHALL be sized by $clog2 and never wrap past their terminal values.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, tx_out=1, ready_out=1, busy=0, baud_q=1, counters=0, shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame; tx_out=1 the cycle after reset is sampled; no tick is generated in the first cycle after reset.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state present, one even-parity bit (XOR of the data bits) sent between the last data bit and STOP.
REQ-026 Macro undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum typedef and the DATA_BITS/STOP_BITS default constants.
REQ-028 Sub-module edge_rise (clk_in, rst, sig_in, pulse_out; register resets to 1) SHALL implement REQ-011.

Verification
REQ-029 Divider period 16 clk_in; send 0xA5, no parity -> tx_out 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles, ready_out high after stop.
REQ-030 UART_TX_PARITY_EN, send 0xA5 -> parity bit 0; send 0x01 -> parity bit 1; frame 11 bits.
REQ-031 valid_in held high with 0x55 then 0x0F -> two complete frames, the second starting on the first tick after ready_out re-asserts, no bit lost or duplicated.
REQ-032 valid_in pulsed with 0xFF during DATA -> ignored, in-flight frame unchanged.
REQ-033 rst asserted during bit 3 of 0x3C -> tx_out=1, ready_out=1, busy=0 next cycle; next accepted byte transmits cleanly.
REQ-034 STOP_BITS=2, DATA_BITS=7, send 0x7F -> 7 data bits, then tx_out high for 2 baud periods before ready_out=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared types and default constants for the UART transmitter   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam int C_DATA_BITS_DEFAULT = 8;
   localparam int C_STOP_BITS_DEFAULT = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd5
`endif
   } uart_state_e;

   // Counter width that stays at least one bit when the count range is a single value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_rise : one-cycle pulse on a rising edge of a synchronous input      |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module edge_rise (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic pulse_out
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig_in;
   end

   // Resetting to 1 suppresses a spurious pulse in the first cycle after reset.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sig_q <= 1'b1;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign pulse_out = sig_in & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx  : UART serial transmitter paced by an external baud clock       |
// |            Optional even parity bit when UART_TX_PARITY_EN is defined.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = C_DATA_BITS_DEFAULT,
   parameter int STOP_BITS = C_STOP_BITS_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic                 tx_out,
   output logic                 busy
);

   localparam int BIT_CNT_W  = cnt_width(DATA_BITS);
   localparam int STOP_CNT_W = cnt_width(STOP_BITS);
   localparam logic [BIT_CNT_W-1:0]  C_BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [STOP_CNT_W-1:0] C_STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);

   uart_state_e             state_q,    state_d;
   logic [DATA_BITS-1:0]    shift_q,    shift_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
   logic [STOP_CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
   logic                    tx_q,       tx_d;
   logic                    ready_q,    ready_d;
   logic                    busy_q,     busy_d;
   logic                    tick;
   logic                    accept;

   edge_rise u_baud_edge (
      .clk_in    (clk_in),
      .rst       (rst),
      .sig_in    (baud_clk),
      .pulse_out (tick)
   );

   assign accept = valid_in & ready_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      ready_d    = ready_q;
      busy_d     = busy_q;

      case (state_q)
         // A tick coinciding with the accept is deliberately not acted on.
         ST_IDLE: begin
            tx_d = 1'b1;
            if (accept) begin
               shift_d = data_in;
               state_d = ST_WAIT;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end

         ST_WAIT: begin
            if (tick) begin
               state_d = ST_START;
               tx_d    = 1'b0;
            end
         end

         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q < C_BIT_LAST) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = shift_q[bit_cnt_d];
               end else begin
`ifdef UART_TX_PARITY_EN
                  state_d    = ST_PARITY;
                  tx_d       = ^shift_q;
`else
                  state_d    = ST_STOP;
                  tx_d       = 1'b1;
                  stop_cnt_d = '0;
`endif
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d    = ST_STOP;
               tx_d       = 1'b1;
               stop_cnt_d = '0;
            end
         end
`endif

         ST_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (stop_cnt_q == C_STOP_LAST) begin
                  state_d = ST_IDLE;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_out    = tx_q;
   assign ready_out = ready_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx : randomized frame-level bench for uart_tx (8N1 and 7N2 DUTs) |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx;

   localparam int DB_A = 8;
   localparam int SB_A = 1;
   localparam int DB_B = 7;
   localparam int SB_B = 2;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk_in   = 1'b0;
   logic       rst      = 1'b1;
   logic       baud_clk = 1'b0;
   logic [7:0] data_a   = '0;
   logic       valid_a  = 1'b0;
   logic       ready_a, tx_a, busy_a;
   logic [6:0] data_b   = '0;
   logic       valid_b  = 1'b0;
   logic       ready_b, tx_b, busy_b;
   logic       sel_b    = 1'b0;
   logic       w_tx, w_ready, w_busy;
   int         cyc      = 0;
   int         n_cmp    = 0;
   int         n_bad    = 0;

   uart_tx #(.DATA_BITS(DB_A), .STOP_BITS(SB_A)) dut_a (
      .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .data_in(data_a),
      .valid_in(valid_a), .ready_out(ready_a), .tx_out(tx_a), .busy(busy_a));

   uart_tx #(.DATA_BITS(DB_B), .STOP_BITS(SB_B)) dut_b (
      .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .data_in(data_b),
      .valid_in(valid_b), .ready_out(ready_b), .tx_out(tx_b), .busy(busy_b));

   assign w_tx    = sel_b ? tx_b    : tx_a;
   assign w_ready = sel_b ? ready_b : ready_a;
   assign w_busy  = sel_b ? busy_b  : busy_a;

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Baud clock: period 16, sampled high at posedges cyc%16 in 0..7, so the
   // rising edge is seen (tick) at posedges whose index is a multiple of 16.
   always @(negedge clk_in) baud_clk = (((cyc + 1) % 16) < 8);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      if (sel_b) begin
         valid_b = v;
         data_b  = d[6:0];
      end else begin
         valid_a = v;
         data_a  = d;
      end
   endtask

   // Offer d, then follow the whole frame on the line against the reference.
   task automatic send_frame(input logic [7:0] d, input bit hold, input logic [7:0] nxt,
                             input bit poke);
      int   db, sb, a, m, nb;
      logic e_bits[$];
      logic [2:0] obs;
      bit   bad;
      db = sel_b ? DB_B : DB_A;
      sb = sel_b ? SB_B : SB_A;
      e_bits = {};
      e_bits.push_back(1'b0);
      for (int i = 0; i < db; i++) e_bits.push_back(d[i]);
      if (PAR != 0) e_bits.push_back(1'($countones(d & 8'((1 << db) - 1)) % 2));
      for (int i = 0; i < sb; i++) e_bits.push_back(1'b1);
      nb = e_bits.size();

      for (int t = 0; t < 400 && w_ready !== 1'b1; t++) @(negedge clk_in);
      check("ready_before_send", {31'd0, w_ready}, 1);
      if (w_ready !== 1'b1) return;
      drive(1'b1, d);
      a = cyc + 1;
      @(negedge clk_in);
      check("busy_after_accept", {30'd0, w_ready, w_busy}, 2'b01);
      if (hold) drive(1'b1, nxt);
      else      drive(1'b0, d);

      m = (a / 16 + 1) * 16;
      for (int t = 0; t < 40 && w_tx !== 1'b0; t++) @(negedge clk_in);
      check("start_edge_cycle", (w_tx === 1'b0) ? cyc : -1, m);
      if (w_tx !== 1'b0) return;

      for (int k = 0; k < nb; k++) begin
         bad = 1'b0;
         obs = {e_bits[k], 2'b01};
         for (int j = 0; j < 16; j++) begin
            if (!bad && ({w_tx, w_ready, w_busy} !== {e_bits[k], 2'b01})) begin
               obs = {w_tx, w_ready, w_busy};
               bad = 1'b1;
            end
            if (poke && k == 4 && j == 5) drive(1'b1, 8'hFF);
            if (poke && k == 4 && j == 6) drive(1'b0, 8'hFF);
            @(negedge clk_in);
         end
         check($sformatf("bit%0d_tx_ready_busy", k), {29'd0, obs}, {29'd0, e_bits[k], 2'b01});
      end
      check("idle_after_stop", {29'd0, w_tx, w_ready, w_busy}, 3'b110);
   endtask

   initial begin
      repeat (4) @(negedge clk_in);
      check("reset_a", {29'd0, tx_a, ready_a, busy_a}, 3'b110);
      check("reset_b", {29'd0, tx_b, ready_b, busy_b}, 3'b110);
      rst = 1'b0;
      repeat (3) @(negedge clk_in);

      sel_b = 1'b0;
      send_frame(8'hA5, 1'b0, 8'h00, 1'b0);
      send_frame(8'h01, 1'b0, 8'h00, 1'b0);
      send_frame(8'h55, 1'b1, 8'h0F, 1'b0);
      send_frame(8'h0F, 1'b0, 8'h00, 1'b0);
      repeat (7) @(negedge clk_in);
      send_frame(8'h96, 1'b0, 8'h00, 1'b1);

      // Abort a frame mid-flight during data bit 3 of 0x3C.
      drive(1'b1, 8'h3C);
      @(negedge clk_in);
      drive(1'b0, 8'h3C);
      for (int t = 0; t < 40 && tx_a !== 1'b0; t++) @(negedge clk_in);
      repeat (16 * 4 + 5) @(negedge clk_in);
      check("pre_reset_bit3", {31'd0, tx_a}, 1);
      check("pre_reset_busy", {31'd0, busy_a}, 1);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      check("reset_abort", {29'd0, tx_a, ready_a, busy_a}, 3'b110);
      repeat ($urandom_range(1, 20)) @(negedge clk_in);
      send_frame(8'($urandom), 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk_in);
         send_frame(8'($urandom), 1'b0, 8'h00, 1'b0);
      end

      sel_b = 1'b1;
      send_frame(8'h7F, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk_in);
         send_frame(8'($urandom_range(0, 127)), 1'b0, 8'h00, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
